// File: rtl/cat_rec_pkg.sv
// cat_rec_pkg: shared constants and types for the cat recognizer APB slave.
//   - Register word addresses and the base of the memory window.
//   - ID register signature byte.
//   - APB slave FSM state encoding.
package cat_rec_pkg;

    localparam int ADDR_CTRL   = 0;
    localparam int ADDR_STATUS = 1;
    localparam int ADDR_RESULT = 2;
    localparam int ADDR_ID     = 3;
    localparam int MEM_BASE    = 4;

    localparam logic [7:0] ID_SIG = 8'hCA;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACCESS  = 2'd1,
        RD_WAIT = 2'd2
    } apb_state_t;

endpackage

// File: rtl/cat_rec_rd_lat_cnt.sv
// cat_rec_rd_lat_cnt: read-latency down-counter for the APB slave RD_WAIT state.
// Ports:
//   clk, rst : clock, synchronous active-high reset
//   load     : (re)load the counter with MEM_RD_LAT (issued with mem_re)
//   en       : count enable, high while the FSM sits in RD_WAIT
//   done     : completion strobe, high in the last RD_WAIT cycle, i.e. the
//              cycle in which memory read data is valid
module cat_rec_rd_lat_cnt #(
    parameter int MEM_RD_LAT = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    input  logic en,
    output logic done
);

    logic [2:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = 3'(MEM_RD_LAT);
        end else if (en && cnt_q != 3'd0) begin
            cnt_d = cnt_q - 3'd1;
        end
    end

    // RD_WAIT starts with the full latency loaded, so the strobe lands
    // exactly MEM_RD_LAT cycles after the mem_re cycle.
    assign done = en && (cnt_q == 3'd1);

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/cat_rec_apb_slave.sv
// cat_rec_apb_slave: APB slave front-end for the cat recognizer.
// Decodes APB into a control/status register bank (CTRL, STATUS, RESULT, ID)
// and a memory window starting at word 4, adds PREADY wait states for memory
// reads, and runs the start/done handshake with the recognition core.
// Ports:
//   clk, rst                          : clock, synchronous active-high reset
//   PSEL/PENABLE/PWRITE/PADDR/PWDATA  : APB request
//   PRDATA/PREADY/PSLVERR             : APB response (registered)
//   mem_we/mem_re/mem_addr/mem_wdata  : memory window port (addr = PADDR - 4)
//   mem_rdata                         : memory read data, MEM_RD_LAT after mem_re
//   core_start                        : one-cycle start pulse to the core
//   core_busy/core_done/core_result   : core status
//   CatRecOut                         : registered last result
// Optional feature macro: CAT_REC_PSLVERR_EN enables PSLVERR for unmapped
// addresses, RO-register writes, rejected STARTs and blocked memory writes.
module cat_rec_apb_slave
    import cat_rec_pkg::*;
#(
    parameter int AMBA_WORD        = 24,
    parameter int AMBA_ADDR_DEPTH  = 13,
    parameter int WEIGHT_PRECISION = 5,
    parameter int MEM_DEPTH        = 4096,
    parameter int MEM_RD_LAT       = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       PSEL,
    input  logic                       PENABLE,
    input  logic                       PWRITE,
    input  logic [AMBA_ADDR_DEPTH-1:0] PADDR,
    input  logic [AMBA_WORD-1:0]       PWDATA,
    output logic [AMBA_WORD-1:0]       PRDATA,
    output logic                       PREADY,
    output logic                       PSLVERR,
    output logic                       mem_we,
    output logic                       mem_re,
    output logic [AMBA_ADDR_DEPTH-1:0] mem_addr,
    output logic [AMBA_WORD-1:0]       mem_wdata,
    input  logic [AMBA_WORD-1:0]       mem_rdata,
    output logic                       core_start,
    input  logic                       core_busy,
    input  logic                       core_done,
    input  logic                       core_result,
    output logic                       CatRecOut
);

`ifdef CAT_REC_PSLVERR_EN
    localparam logic ERR_EN = 1'b1;
`else
    localparam logic ERR_EN = 1'b0;
`endif

    apb_state_t                 state_q, state_d;
    logic                       pready_q, pready_d;
    logic                       pslverr_q, pslverr_d;
    logic [AMBA_WORD-1:0]       prdata_q, prdata_d;
    logic                       mem_we_q, mem_we_d;
    logic                       mem_re_q, mem_re_d;
    logic [AMBA_ADDR_DEPTH-1:0] mem_addr_q, mem_addr_d;
    logic [AMBA_WORD-1:0]       mem_wdata_q, mem_wdata_d;
    logic                       start_pend_q, start_pend_d;
    logic                       core_start_q, core_start_d;
    logic                       done_q, done_d;
    logic                       cat_rec_out_q, cat_rec_out_d;
    logic [7:0]                 run_cnt_q, run_cnt_d;

    logic                       err;
    logic                       clr_done;
    logic                       cnt_load, cnt_en, cnt_done;
    logic                       start_busy;

    // ---------------------------------------------------------------- decode
    logic [31:0] addr_ext;
    logic        is_ctrl, is_status, is_result, is_id, is_reg, is_mem;

    assign addr_ext  = 32'(PADDR);
    assign is_ctrl   = (addr_ext == 32'(ADDR_CTRL));
    assign is_status = (addr_ext == 32'(ADDR_STATUS));
    assign is_result = (addr_ext == 32'(ADDR_RESULT));
    assign is_id     = (addr_ext == 32'(ADDR_ID));
    assign is_reg    = (addr_ext <  32'(MEM_BASE));
    assign is_mem    = (addr_ext >= 32'(MEM_BASE)) &&
                       (addr_ext <  32'(MEM_BASE + MEM_DEPTH));

    // A START accepted in the previous cycle has not reached the core yet,
    // so core_busy alone would let a back-to-back START through twice.
    assign start_busy = core_busy | start_pend_q | core_start_q;

    logic [AMBA_WORD-1:0] reg_rdata;

    always_comb begin
        reg_rdata = '0;
        if (is_status) begin
            reg_rdata[2:0] = {cat_rec_out_q, done_q, core_busy};
        end else if (is_result) begin
            reg_rdata[8:0] = {run_cnt_q, cat_rec_out_q};
        end else if (is_id) begin
            reg_rdata[15:0] = {8'(WEIGHT_PRECISION), ID_SIG};
        end
    end

    // ------------------------------------------------------- read latency
    cat_rec_rd_lat_cnt #(
        .MEM_RD_LAT(MEM_RD_LAT)
    ) u_rd_lat_cnt (
        .clk (clk),
        .rst (rst),
        .load(cnt_load),
        .en  (cnt_en),
        .done(cnt_done)
    );

    // ------------------------------------------------------------ next state
    // The transfer is decoded in the setup phase (PSEL & !PENABLE) so that
    // the registered PREADY/PSLVERR/mem_we/mem_re are already high in the
    // first ACCESS cycle.
    always_comb begin
        state_d      = state_q;
        pready_d     = 1'b0;
        prdata_d     = '0;
        err          = 1'b0;
        mem_we_d     = 1'b0;
        mem_re_d     = 1'b0;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        start_pend_d = 1'b0;
        core_start_d = start_pend_q;
        clr_done     = 1'b0;
        cnt_load     = 1'b0;
        cnt_en       = 1'b0;

        case (state_q)
            IDLE: begin
                if (PSEL && !PENABLE) begin
                    state_d = ACCESS;
                    if (is_mem && !PWRITE) begin
                        mem_re_d   = 1'b1;
                        mem_addr_d = PADDR - AMBA_ADDR_DEPTH'(MEM_BASE);
                        cnt_load   = 1'b1;
                    end else begin
                        pready_d = 1'b1;
                        if (PWRITE) begin
                            if (is_mem) begin
                                if (core_busy) begin
                                    err = 1'b1;
                                end else begin
                                    mem_we_d    = 1'b1;
                                    mem_addr_d  = PADDR - AMBA_ADDR_DEPTH'(MEM_BASE);
                                    mem_wdata_d = PWDATA;
                                end
                            end else if (is_ctrl) begin
                                if (PWDATA[0]) begin
                                    if (start_busy) begin
                                        err = 1'b1;
                                    end else begin
                                        start_pend_d = 1'b1;
                                        clr_done     = 1'b1;
                                    end
                                end
                            end else begin
                                // RO register or unmapped address
                                err = 1'b1;
                            end
                        end else begin
                            prdata_d = reg_rdata;
                            err      = !is_reg;
                        end
                    end
                end
            end

            ACCESS: begin
                if (!PSEL) begin
                    state_d = IDLE;
                end else if (mem_re_q) begin
                    state_d = RD_WAIT;
                end else begin
                    state_d = IDLE;
                end
            end

            RD_WAIT: begin
                if (!PSEL) begin
                    state_d = IDLE;
                end else begin
                    cnt_en = 1'b1;
                    if (cnt_done) begin
                        pready_d = 1'b1;
                        prdata_d = mem_rdata;
                        state_d  = IDLE;
                    end
                end
            end

            default: state_d = IDLE;
        endcase

        pslverr_d = ERR_EN & err;
    end

    // Core status: a completion always sets DONE, even when a START clears
    // it in the same cycle.
    always_comb begin
        done_d        = done_q;
        cat_rec_out_d = cat_rec_out_q;
        run_cnt_d     = run_cnt_q;
        if (clr_done) begin
            done_d = 1'b0;
        end
        if (core_done) begin
            done_d        = 1'b1;
            cat_rec_out_d = core_result;
            run_cnt_d     = run_cnt_q + 8'd1;
        end
    end

    // ---------------------------------------------------------------- flops
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            pready_q      <= 1'b0;
            pslverr_q     <= 1'b0;
            prdata_q      <= '0;
            mem_we_q      <= 1'b0;
            mem_re_q      <= 1'b0;
            mem_addr_q    <= '0;
            mem_wdata_q   <= '0;
            start_pend_q  <= 1'b0;
            core_start_q  <= 1'b0;
            done_q        <= 1'b0;
            cat_rec_out_q <= 1'b0;
            run_cnt_q     <= '0;
        end else begin
            state_q       <= state_d;
            pready_q      <= pready_d;
            pslverr_q     <= pslverr_d;
            prdata_q      <= prdata_d;
            mem_we_q      <= mem_we_d;
            mem_re_q      <= mem_re_d;
            mem_addr_q    <= mem_addr_d;
            mem_wdata_q   <= mem_wdata_d;
            start_pend_q  <= start_pend_d;
            core_start_q  <= core_start_d;
            done_q        <= done_d;
            cat_rec_out_q <= cat_rec_out_d;
            run_cnt_q     <= run_cnt_d;
        end
    end

    assign PRDATA     = prdata_q;
    assign PREADY     = pready_q;
    assign PSLVERR    = pslverr_q;
    assign mem_we     = mem_we_q;
    assign mem_re     = mem_re_q;
    assign mem_addr   = mem_addr_q;
    assign mem_wdata  = mem_wdata_q;
    assign core_start = core_start_q;
    assign CatRecOut  = cat_rec_out_q;

endmodule
